data_mem_arbiter: RTL and testbench

- Shares the single-port 32x16 data memory between two requesters: the CPU load/store unit (port A) and the debug/loader port (port B).
- Sequences every access as a fixed 3-state transaction and returns registered read data with a one-cycle ack.
- Flags out-of-range addresses.
- Sits between the core datapath/debug unit and the data memory, whose read input is high for a read and low for a write.

---
 rtl/data_mem_pkg.sv | 32 +++
 rtl/rr_arb2.sv | 40 ++++
 rtl/data_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory arbiter slice.
// Holds widths, depth, port ids, FSM states and the latched request.
package data_mem_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;
  localparam int unsigned DEPTH = 32;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

  // Winner bookkeeping kept across ACCESS/DONE.
  // Address and write data live in mem_addr/mem_wdata.
  typedef struct packed {
    logic port;
    logic we;
    logic err;
  } xact_t;

  function automatic logic out_of_range(
    input logic [ADDR_W-1:0] a
  );
    return 32'(a) >= DEPTH;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin, or fixed A-first with MEMARB_FIXED_PRIO_EN.
// Ports: a_req, b_req, last_b (last grant was B) in; one-hot gnt out.
module rr_arb2 (
  input  logic       a_req,
  input  logic       b_req,
  input  logic       last_b,
  output logic [1:0] gnt
);

`ifdef MEMARB_FIXED_PRIO_EN

  logic unused_last;
  assign unused_last = last_b;

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      a_req:  gnt = 2'b01;
      b_req:  gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
  end

`else

  // On a tie the port not granted last wins.
  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      a_req && !b_req: gnt = 2'b01;
      b_req && !a_req: gnt = 2'b10;
      a_req && b_req:  gnt = last_b ? 2'b01
                                    : 2'b10;
      default:         gnt = 2'b00;
    endcase
  end

`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares a 32x16 data memory between port A (LSU) and port B (debug).
// Ports: clk, rst_n; a_*/b_* req,we,addr,wdata,ack,rdata,err; mem_*.
// Each access is IDLE -> ACCESS -> DONE; ack/rdata/err valid in DONE.
// MEMARB_FIXED_PRIO_EN: A always wins ties, no last-grant pointer.
module data_mem_arbiter
  import data_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state;
  xact_t             cur;
  xact_t             nxt;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_wdata;
  logic [1:0]        gnt;
  logic              last_b;

  rr_arb2 u_arb (
    .a_req  (a_req),
    .b_req  (b_req),
    .last_b (last_b),
    .gnt    (gnt)
  );

`ifdef MEMARB_FIXED_PRIO_EN
  assign last_b = PORT_B;
`else
  // Reset to B so A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= PORT_B;
    end else if (state == DONE) begin
      last_b <= cur.port;
    end
  end
`endif

  always_comb begin
    nxt       = '0;
    nxt_addr  = a_addr;
    nxt_wdata = a_wdata;
    nxt.port  = PORT_A;
    nxt.we    = a_we;
    if (gnt[1]) begin
      nxt.port  = PORT_B;
      nxt.we    = b_we;
      nxt_addr  = b_addr;
      nxt_wdata = b_wdata;
    end
    nxt.err = out_of_range(nxt_addr);
  end

  // mem_read drops only for the single ACCESS cycle of
  // an in-range write; reset forces it high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur       <= '0;
      a_ack     <= 1'b0;
      a_err     <= 1'b0;
      a_rdata   <= '0;
      b_ack     <= 1'b0;
      b_err     <= 1'b0;
      b_rdata   <= '0;
      mem_addr  <= '0;
      mem_read  <= 1'b1;
      mem_wdata <= '0;
    end else begin
      a_ack    <= 1'b0;
      a_err    <= 1'b0;
      b_ack    <= 1'b0;
      b_err    <= 1'b0;
      mem_read <= 1'b1;
      unique case (state)
        IDLE: begin
          if (|gnt) begin
            cur      <= nxt;
            mem_addr <= nxt_addr;
            if (nxt.we && !nxt.err) begin
              mem_read  <= 1'b0;
              mem_wdata <= nxt_wdata;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (cur.port == PORT_A) begin
            a_ack <= 1'b1;
            a_err <= cur.err;
            if (cur.err) begin
              a_rdata <= '0;
            end else if (!cur.we) begin
              a_rdata <= mem_rdata;
            end
          end else begin
            b_ack <= 1'b1;
            b_err <= cur.err;
            if (cur.err) begin
              b_rdata <= '0;
            end else if (!cur.we) begin
              b_rdata <= mem_rdata;
            end
          end
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized bench for data_mem_arbiter against a transaction-level model.
// Memory model: 32 words preloaded with word i = i.
module tb_data_mem_arbiter;

`ifdef MEMARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [5:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, a_err, b_ack, b_err;
  logic [15:0] a_rdata, b_rdata;
  logic [5:0]  mem_addr;
  logic        mem_read;
  logic [15:0] mem_wdata, mem_rdata;

  logic [15:0] tbmem [0:31];
  logic        load;

  logic [15:0] ref_mem [0:31];
  logic [15:0] exp_rd [0:1];
  int          last_g;
  int          nvec = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_ack     (a_ack),
    .a_rdata   (a_rdata),
    .a_err     (a_err),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_ack     (b_ack),
    .b_rdata   (b_rdata),
    .b_err     (b_err),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  assign mem_rdata = (mem_addr < 6'd32) ? tbmem[mem_addr[4:0]] : 16'h0;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 32; i++) tbmem[i] <= 16'(i);
    end else if (!mem_read && mem_addr < 6'd32) begin
      tbmem[mem_addr[4:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_g = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  // One round: the chosen ports request together and each holds
  // until acked. Model serves them in arbitration order.
  task automatic txn(input bit ra, input bit rb,
                     input bit wa, input bit wb,
                     input logic [5:0] aa, input logic [5:0] ab,
                     input logic [15:0] da, input logic [15:0] db);
    int ord [0:1];
    int n = 0;
    int got = 0;
    int cyc = 0;
    int low = 0;
    int elow = 0;
    int p;
    bit w;
    logic [5:0] ad;
    logic [15:0] dt;
    if (ra && rb) begin
      ord[0] = FIXED ? 0 : (last_g == 0 ? 1 : 0);
      ord[1] = 1 - ord[0];
      n = 2;
    end else begin
      ord[0] = rb ? 1 : 0;
      ord[1] = 0;
      n = (ra || rb) ? 1 : 0;
    end
    @(negedge clk);
    a_req = ra; a_we = wa; a_addr = aa; a_wdata = da;
    b_req = rb; b_we = wb; b_addr = ab; b_wdata = db;
    while (got < n && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (!mem_read) low++;
      if (a_ack || b_ack) begin
        p  = ord[got];
        w  = p == 1 ? wb : wa;
        ad = p == 1 ? ab : aa;
        dt = p == 1 ? db : da;
        if (ad >= 6'd32) begin
          exp_rd[p] = 16'h0;
        end else if (w) begin
          ref_mem[ad[4:0]] = dt;
          elow++;
        end else begin
          exp_rd[p] = ref_mem[ad[4:0]];
        end
        chk("ack_port", {a_ack, b_ack}, p == 1 ? 2'b01 : 2'b10);
        chk("ack_lat", cyc, got == 0 ? 2 : 5);
        chk("rdata", p == 1 ? b_rdata : a_rdata, exp_rd[p]);
        chk("err", p == 1 ? b_err : a_err, ad >= 6'd32);
        if (p == 1) b_req = 1'b0;
        else a_req = 1'b0;
        last_g = p;
        got++;
      end
    end
    if (got < n) chk("timeout", got, n);
    chk("wr_strobes", low, elow);
  endtask

  initial begin
    int cnt;
    int sel;
    logic [5:0] ra6, rb6;
    load = 1'b1;
    a_we = 0; b_we = 0;
    a_addr = 0; b_addr = 0;
    a_wdata = 0; b_wdata = 0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 16'(i);
    do_reset();
    load = 1'b0;
    #1;
    chk("rst_a_ack", a_ack, 0);
    chk("rst_b_ack", b_ack, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_b_err", b_err, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_read", mem_read, 1);
    chk("rst_mem_wdata", mem_wdata, 0);

    txn(1, 0, 0, 0, 6'd5, 0, 0, 0);
    chk("rd5", a_rdata, 16'h0005);

    txn(0, 1, 0, 1, 0, 6'd10, 0, 16'hBEEF);
    txn(1, 0, 0, 0, 6'd10, 0, 0, 0);
    chk("rd10", a_rdata, 16'hBEEF);

    do_reset();
    txn(1, 1, 0, 0, 6'd1, 6'd2, 0, 0);
    chk("tie_a", a_rdata, 16'h0001);
    chk("tie_b", b_rdata, 16'h0002);
    repeat (3) txn(1, 1, 0, 0, 6'd4, 6'd9, 0, 0);

    txn(1, 0, 1, 0, 6'd40, 0, 16'h1234, 0);
    chk("oor_mem8", tbmem[8], ref_mem[8]);

    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1;
    b_addr = 6'd3; b_wdata = 16'hAAAA;
    @(negedge clk);
    chk("mid_rd", mem_read, 0);
    chk("mid_addr", mem_addr, 6'd3);
    rst_n = 1'b0;
    b_req = 1'b0;
    #1;
    chk("mid_rst_rd", mem_read, 1);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_wd", mem_wdata, 0);
    chk("mid_rst_brd", b_rdata, 0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      cnt += a_ack + b_ack;
    end
    chk("mid_noack", cnt, 0);
    chk("mid_mem3", tbmem[3], 16'h0003);
    rst_n = 1'b1;
    last_g = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;

    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 6'd7;
    @(negedge clk);
    a_req = 1'b0;
    @(negedge clk);
    chk("drop_ack", a_ack, 1);
    chk("drop_rd", a_rdata, ref_mem[7]);
    exp_rd[0] = ref_mem[7];
    last_g = 0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      cnt += a_ack + b_ack;
    end
    chk("drop_once", cnt, 0);

    for (int k = 0; k < 80; k++) begin
      sel = $urandom_range(1, 3);
      ra6 = 6'($urandom_range(0, 47));
      rb6 = 6'($urandom_range(0, 47));
      txn(sel[0], sel[1], 1'($urandom), 1'($urandom),
          ra6, rb6, 16'($urandom), 16'($urandom));
    end

    @(negedge clk);
    for (int i = 0; i < 32; i++) chk("mem_final", tbmem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
